// File: rtl/demux_buffered.sv
// rtl/demux_buffered.sv - one-to-many router with a single-entry registered buffer per output lane
module demux_buffered #(
  parameter int CHANNELS  = 2,
  parameter int BUS_SIZE  = 32,
  parameter int CNT_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [$clog2(CHANNELS)-1:0]  selector,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [BUS_SIZE-1:0]          data_in,
  input  logic                         flush,
  output logic [CHANNELS-1:0]          out_valid,
  input  logic [CHANNELS-1:0]          out_ready,
  output logic [CHANNELS*BUS_SIZE-1:0] data_out,
  output logic                         bad_sel,
  output logic [CNT_WIDTH-1:0]         drop_count
);

  localparam int SEL_W = $clog2(CHANNELS);

  logic [CHANNELS-1:0]          lane_hit;
  logic [CHANNELS-1:0]          valid_q;
  logic [CHANNELS*BUS_SIZE-1:0] data_q;
  logic                         in_range;
  logic                         accept;

  // One-hot decode; an all-zero result means the selector is past the last lane.
  always_comb begin
    lane_hit = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      lane_hit[k] = (selector == SEL_W'(k));
    end
  end

  assign in_range = |lane_hit;
  assign in_ready = flush || !in_range || (|(lane_hit & (~valid_q | out_ready)));
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      data_q  <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (accept && lane_hit[k]) begin
          data_q[k*BUS_SIZE +: BUS_SIZE] <= data_in;
          valid_q[k]                     <= 1'b1;
        end else if (out_ready[k]) begin
          valid_q[k] <= 1'b0;
        end
      end
    end
  end

  // Drop accounting ignores flush so that discarded misrouted words are never hidden.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bad_sel    <= 1'b0;
      drop_count <= '0;
    end else if (accept && !in_range) begin
      bad_sel <= 1'b1;
      if (drop_count != {CNT_WIDTH{1'b1}}) begin
        drop_count <= drop_count + 1'b1;
      end
    end
  end

  assign out_valid = valid_q;
  assign data_out  = data_q;

endmodule

// File: tb/tb_demux_buffered.sv
// tb/tb_demux_buffered.sv - directed self-checking bench for demux_buffered at 4 and 3 lanes
module tb_demux_buffered;

  logic         clk = 1'b0;
  logic         reset_n;

  logic [1:0]   sel4;
  logic         in_valid4;
  logic         in_ready4;
  logic [31:0]  data_in4;
  logic         flush4;
  logic [3:0]   out_valid4;
  logic [3:0]   out_ready4;
  logic [127:0] data_out4;
  logic         bad_sel4;
  logic [7:0]   drop_count4;

  logic [1:0]   sel3;
  logic         in_valid3;
  logic         in_ready3;
  logic [31:0]  data_in3;
  logic         flush3;
  logic [2:0]   out_valid3;
  logic [2:0]   out_ready3;
  logic [95:0]  data_out3;
  logic         bad_sel3;
  logic [7:0]   drop_count3;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  demux_buffered #(.CHANNELS(4), .BUS_SIZE(32), .CNT_WIDTH(8)) u4 (
    .clk(clk), .reset_n(reset_n), .selector(sel4), .in_valid(in_valid4),
    .in_ready(in_ready4), .data_in(data_in4), .flush(flush4),
    .out_valid(out_valid4), .out_ready(out_ready4), .data_out(data_out4),
    .bad_sel(bad_sel4), .drop_count(drop_count4)
  );

  demux_buffered #(.CHANNELS(3), .BUS_SIZE(32), .CNT_WIDTH(8)) u3 (
    .clk(clk), .reset_n(reset_n), .selector(sel3), .in_valid(in_valid3),
    .in_ready(in_ready3), .data_in(data_in3), .flush(flush3),
    .out_valid(out_valid3), .out_ready(out_ready3), .data_out(data_out3),
    .bad_sel(bad_sel3), .drop_count(drop_count3)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic       ready_ok;
    logic [31:0] w;

    reset_n    = 1'b0;
    sel4       = '0; in_valid4 = 1'b0; data_in4 = '0; flush4 = 1'b0; out_ready4 = '0;
    sel3       = '0; in_valid3 = 1'b0; data_in3 = '0; flush3 = 1'b0; out_ready3 = '0;
    #12;
    chk("rst_valid4", out_valid4, 4'b0000);
    chk("rst_data4", data_out4, 128'h0);
    chk("rst_bad3", bad_sel3, 1'b0);
    chk("rst_drop3", drop_count3, 8'd0);
    reset_n = 1'b1;
    step;

    // Single accept into lane 2
    in_valid4 = 1'b1; sel4 = 2'd2; data_in4 = 32'hDEADBEEF;
    #1 chk("t1_ready", in_ready4, 1'b1);
    step;
    in_valid4 = 1'b0;
    chk("t1_valid", out_valid4, 4'b0100);
    chk("t1_data", data_out4, {32'h0, 32'hDEADBEEF, 64'h0});

    // Backpressure on full lane 2, then another lane still accepts
    in_valid4 = 1'b1; sel4 = 2'd2; data_in4 = 32'h1;
    #1 chk("t2_ready_blocked", in_ready4, 1'b0);
    step;
    chk("t2_lane2_kept", data_out4[95:64], 32'hDEADBEEF);
    chk("t2_valid_kept", out_valid4, 4'b0100);
    sel4 = 2'd0; data_in4 = 32'h55;
    #1 chk("t2_ready_lane0", in_ready4, 1'b1);
    step;
    in_valid4 = 1'b0;
    chk("t2_valid", out_valid4, 4'b0101);
    chk("t2_lane0", data_out4[31:0], 32'h55);

    // Pop and accept on the same lane in one cycle
    out_ready4 = 4'b0100;
    in_valid4 = 1'b1; sel4 = 2'd2; data_in4 = 32'h12345678;
    #1 chk("t3_ready", in_ready4, 1'b1);
    step;
    chk("t3_valid2", out_valid4[2], 1'b1);
    chk("t3_lane2", data_out4[95:64], 32'h12345678);
    for (int i = 0; i < 8; i++) begin
      w = 32'hA000 + i;
      data_in4 = w;
      #1 chk("t3_stream_ready", in_ready4, 1'b1);
      step;
      chk("t3_stream_data", data_out4[95:64], w);
      chk("t3_stream_valid", out_valid4, 4'b0101);
    end
    in_valid4 = 1'b0;
    step;
    chk("t3_pop_valid", out_valid4, 4'b0001);
    chk("t3_pop_hold", data_out4[95:64], 32'hA007);
    out_ready4 = 4'b0000;

    // Out-of-range selector on the 3-lane instance
    in_valid3 = 1'b1; sel3 = 2'd3; data_in3 = 32'hBAD0;
    #1 chk("t4_ready", in_ready3, 1'b1);
    step;
    chk("t4_bad_first", bad_sel3, 1'b1);
    chk("t4_drop_first", drop_count3, 8'd1);
    ready_ok = 1'b1;
    for (int n = 2; n <= 300; n++) begin
      if (in_ready3 !== 1'b1) ready_ok = 1'b0;
      step;
      if (n == 200) chk("t4_drop_200", drop_count3, 8'd200);
    end
    in_valid3 = 1'b0;
    chk("t4_ready_throughout", ready_ok, 1'b1);
    chk("t4_drop_sat", drop_count3, 8'd255);
    chk("t4_bad", bad_sel3, 1'b1);
    chk("t4_valid", out_valid3, 3'b000);
    chk("t4_data", data_out3, 96'h0);
    flush3 = 1'b1;
    step;
    flush3 = 1'b0;
    chk("t4_flush_keep_drop", drop_count3, 8'd255);
    chk("t4_flush_keep_bad", bad_sel3, 1'b1);

    // Flush overrides a same-cycle accept
    in_valid4 = 1'b1; sel4 = 2'd1; data_in4 = 32'h77;
    step;
    chk("t5_fill", out_valid4, 4'b0011);
    flush4 = 1'b1; sel4 = 2'd1; data_in4 = 32'hAA;
    #1 chk("t5_flush_ready", in_ready4, 1'b1);
    step;
    flush4 = 1'b0; in_valid4 = 1'b0;
    chk("t5_valid", out_valid4, 4'b0000);
    chk("t5_data", data_out4, {32'h0, 32'hA007, 32'h77, 32'h55});

    // Asynchronous reset between edges
    in_valid4 = 1'b1; sel4 = 2'd0; data_in4 = 32'h99;
    step;
    in_valid4 = 1'b0;
    chk("t6_pre", out_valid4, 4'b0001);
    #3 reset_n = 1'b0;
    #1;
    chk("t6_valid", out_valid4, 4'b0000);
    chk("t6_data", data_out4, 128'h0);
    chk("t6_drop", drop_count3, 8'd0);
    chk("t6_bad", bad_sel3, 1'b0);
    #1 reset_n = 1'b1;
    step;
    chk("t6_idle", out_valid4, 4'b0000);
    in_valid4 = 1'b1; sel4 = 2'd0; data_in4 = 32'hCAFE;
    step;
    in_valid4 = 1'b0;
    chk("t6_accept_valid", out_valid4, 4'b0001);
    chk("t6_accept_data", data_out4[31:0], 32'hCAFE);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
